// File: rtl/johnson_monitor.sv
// Monitors a 4-bit Johnson counter: decodes phase, judges step legality,
// tracks lock/fault state and counts completed 8-phase cycles.
module johnson_monitor #(
  parameter int unsigned CYC_W  = 8,
  parameter int unsigned LOCK_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       q,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             legal,
  output logic             locked,
  output logic             err,
  output logic [CYC_W-1:0] cycles,
  output logic             wrap
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  logic [3:0]       q_d;
  logic             prev_valid;

  logic [2:0] cur_phase, prev_phase;
  logic       cur_legal, prev_legal;
  logic       is_step, is_hold, is_bad, is_wrap;

  // Returns {legal, phase} for a 4-bit Johnson code.
  function automatic logic [3:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = {1'b1, 3'd0};
      4'h1:    decode = {1'b1, 3'd1};
      4'h3:    decode = {1'b1, 3'd2};
      4'h7:    decode = {1'b1, 3'd3};
      4'hF:    decode = {1'b1, 3'd4};
      4'hE:    decode = {1'b1, 3'd5};
      4'hC:    decode = {1'b1, 3'd6};
      4'h8:    decode = {1'b1, 3'd7};
      default: decode = {1'b0, 3'd0};
    endcase
  endfunction

  // Sample classification against the previous sample.
  always_comb begin
    {cur_legal, cur_phase}   = decode(q);
    {prev_legal, prev_phase} = decode(q_d);
    is_step = prev_valid && cur_legal && prev_legal &&
              (cur_phase == 3'(prev_phase + 3'd1));
    is_hold = prev_valid && cur_legal && !is_step && (q == q_d);
    is_bad  = !cur_legal || (prev_valid && !is_step && !is_hold);
    is_wrap = is_step && (state == LOCKED) && (prev_phase == 3'd7);
  end

  // Next-state logic for lock tracking.
  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    case (state)
      UNLOCK: begin
        if (is_bad) begin
          step_cnt_nxt = '0;
        end else if (is_step) begin
          if (CNT_W'(step_cnt + CNT_W'(1)) == CNT_W'(LOCK_N)) begin
            state_nxt    = LOCKED;
            step_cnt_nxt = '0;
          end else begin
            step_cnt_nxt = CNT_W'(step_cnt + CNT_W'(1));
          end
        end
      end
      LOCKED: begin
        if (is_bad) state_nxt = FAULT;
      end
      FAULT: begin
        // clr_err overrides whatever the sample looks like
        if (clr_err) begin
          state_nxt    = UNLOCK;
          step_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = UNLOCK;
        step_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCK;
      step_cnt   <= '0;
      q_d        <= '0;
      prev_valid <= 1'b0;
      phase      <= '0;
      legal      <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      cycles     <= '0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_cnt   <= step_cnt_nxt;
      q_d        <= q;
      prev_valid <= 1'b1;
      legal      <= cur_legal;
      if (cur_legal) phase <= cur_phase;
      locked     <= (state_nxt == LOCKED);
      err        <= (state_nxt == FAULT);
      wrap       <= is_wrap;
      if (is_wrap) cycles <= CYC_W'(cycles + CYC_W'(1));
    end
  end

endmodule

// File: tb/tb_johnson_monitor.sv
// Randomized scoreboard bench for johnson_monitor with a sequence-level model.
module tb_johnson_monitor;

  localparam int unsigned CYC_W  = 2;
  localparam int unsigned LOCK_N = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       q;
  logic             clr_err;
  logic [2:0]       phase;
  logic             legal, locked, err, wrap;
  logic [CYC_W-1:0] cycles;

  johnson_monitor #(.CYC_W(CYC_W), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .reset(reset), .q(q), .clr_err(clr_err),
    .phase(phase), .legal(legal), .locked(locked), .err(err),
    .cycles(cycles), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       phase;
    logic             legal;
    logic             locked;
    logic             err;
    logic [CYC_W-1:0] cycles;
    logic             wrap;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Johnson ring in phase order; a code's phase is its position here.
  logic [3:0] ring [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  function automatic int ring_pos(input logic [3:0] code);
    for (int i = 0; i < 8; i++) if (ring[i] == code) return i;
    return -1;
  endfunction

  // Model: mode 0 = hunting for lock, 1 = locked, 2 = faulted.
  int         m_mode, m_run, m_phase, m_cycles;
  bit         m_have_prev, m_legal, m_wrap;
  logic [3:0] m_prev;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_phase = 0; m_cycles = 0;
    m_have_prev = 0; m_legal = 0; m_wrap = 0; m_prev = 4'h0;
  endtask

  task automatic model_step(input bit rst, input logic [3:0] code, input bit clr);
    int pos, ppos;
    string kind;
    if (rst) begin
      model_reset();
      return;
    end
    pos  = ring_pos(code);
    ppos = m_have_prev ? ring_pos(m_prev) : -1;
    if (pos < 0)                                 kind = "bad";
    else if (!m_have_prev)                       kind = "first";
    else if (ppos >= 0 && pos == (ppos + 1) % 8) kind = "step";
    else if (code == m_prev)                     kind = "hold";
    else                                         kind = "bad";
    m_wrap = (m_mode == 1) && (kind == "step") && (ppos == 7);
    if (m_wrap) m_cycles = (m_cycles + 1) % (1 << CYC_W);
    case (m_mode)
      0: if (kind == "bad") m_run = 0;
         else if (kind == "step") begin
           m_run++;
           if (m_run == LOCK_N) begin m_mode = 1; m_run = 0; end
         end
      1: if (kind == "bad") m_mode = 2;
      default: if (clr) begin m_mode = 0; m_run = 0; end
    endcase
    if (pos >= 0) m_phase = pos;
    m_legal     = (pos >= 0);
    m_prev      = code;
    m_have_prev = 1;
  endtask

  task automatic apply(input bit rst, input logic [3:0] code, input bit clr);
    exp_t e;
    @(negedge clk);
    reset = rst; q = code; clr_err = clr;
    model_step(rst, code, clr);
    e.phase  = 3'(m_phase);
    e.legal  = m_legal;
    e.locked = (m_mode == 1);
    e.err    = (m_mode == 2);
    e.cycles = CYC_W'(m_cycles);
    e.wrap   = m_wrap;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, one per applied sample.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      chk("phase",  int'(phase),  int'(e.phase));
      chk("legal",  int'(legal),  int'(e.legal));
      chk("locked", int'(locked), int'(e.locked));
      chk("err",    int'(err),    int'(e.err));
      chk("cycles", int'(cycles), int'(e.cycles));
      chk("wrap",   int'(wrap),   int'(e.wrap));
    end
  end

  // Directed prefix: bit5 = reset, bit4 = clr_err, [3:0] = q.
  logic [5:0] directed[$] = '{
    6'h20, 6'h20,
    6'h00, 6'h01, 6'h03, 6'h07,
    6'h0F, 6'h0E, 6'h0C, 6'h08, 6'h00,
    6'h05, 6'h01, 6'h03, 6'h07, 6'h0F, 6'h0E, 6'h0C, 6'h08, 6'h00, 6'h01, 6'h03,
    6'h17, 6'h0F, 6'h0E,
    6'h0C, 6'h08, 6'h00, 6'h01, 6'h07, 6'h15,
    6'h00, 6'h01, 6'h03, 6'h03, 6'h03, 6'h03,
    6'h07, 6'h0F, 6'h0E, 6'h0C, 6'h08, 6'h00, 6'h01, 6'h03,
    6'h07, 6'h0F, 6'h0E, 6'h0C, 6'h08, 6'h00, 6'h01, 6'h03,
    6'h07, 6'h0F, 6'h0E, 6'h0C, 6'h08, 6'h00, 6'h01, 6'h03,
    6'h07, 6'h0F, 6'h0E, 6'h0C, 6'h08, 6'h00, 6'h01, 6'h03,
    6'h20, 6'h01, 6'h03, 6'h07
  };

  initial begin
    logic [3:0] last, code;
    logic [5:0] d;
    int r, p;
    bit rst, clr;
    reset = 1'b1; q = 4'h0; clr_err = 1'b0;
    model_reset();
    last = 4'h0;
    foreach (directed[i]) begin
      d = directed[i];
      apply(d[5], d[3:0], d[4]);
      last = d[3:0];
    end
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      p = ring_pos(last);
      if (r < 70)      code = (p >= 0) ? ring[(p + 1) % 8] : ring[$urandom_range(0, 7)];
      else if (r < 80) code = last;
      else if (r < 88) code = ring[$urandom_range(0, 7)];
      else if (r < 95) code = 4'($urandom_range(0, 15));
      else             code = (p >= 0) ? ring[(p + 1) % 8] : 4'h0;
      clr = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      apply(rst, code, clr);
      last = code;
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got %0d vectors, expected run to complete", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/johnson_monitor.md
JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001 SHALL have parameter CYC_W, default 8: width of the completed-cycle counter.
REQ-002 SHALL have parameter LOCK_N, default 2: consecutive successor steps required to lock (1..15).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port q, input, 4: Johnson count from the upstream 4-bit Johnson counter.
REQ-006 SHALL have port clr_err, input, 1: clears the FAULT state.
REQ-007 SHALL have port phase, output, 3: decoded phase index of the last sample.
REQ-008 SHALL have port legal, output, 1: last sample was a valid Johnson code.
REQ-009 SHALL have port locked, output, 1: FSM is in LOCKED.
REQ-010 SHALL have port err, output, 1: FSM is in FAULT (sticky).
REQ-011 SHALL have port cycles, output, CYC_W: count of completed 8-phase cycles while locked.
REQ-012 SHALL have port wrap, output, 1: one-cycle pulse on each cycles increment.

Function
REQ-013 SHALL sample q on every posedge clk (reset low); all outputs registered, 1-cycle latency from the q sample.
REQ-014 SHALL decode 0x0,0x1,0x3,0x7,0xF,0xE,0xC,0x8 to phase 0..7; legal=1 for these codes.
REQ-015 SHALL, for codes 0x2,0x4,0x5,0x6,0x9,0xA,0xB,0xD, drive legal=0 and leave phase at its previous value.
REQ-016 SHALL hold the previous sample (q_d) plus a prev_valid flag, cleared by reset and set after the first sample.
REQ-017 SHALL classify each sample with prev_valid=1 as STEP (phase = prev phase+1 mod 8), HOLD (code == q_d), or BAD (illegal code, or legal but not STEP/HOLD).
REQ-018 SHALL treat the first sample after reset (prev_valid=0) as neither STEP nor BAD, except that an illegal code is BAD.
REQ-019 SHALL implement FSM states UNLOCK, LOCKED, FAULT; reset state UNLOCK.
REQ-020 SHALL, in UNLOCK, increment a step counter on STEP, keep it on HOLD, and zero it on BAD; on reaching LOCK_N, enter LOCKED and zero the counter.
REQ-021 SHALL, in LOCKED, stay on STEP/HOLD and enter FAULT on BAD.
REQ-022 SHALL, in FAULT, ignore sample classification and enter UNLOCK with step counter 0 when clr_err=1; clr_err has no effect in UNLOCK or LOCKED.
REQ-023 SHALL, when clr_err=1 and a BAD sample arrive together in FAULT, resolve to UNLOCK (clr_err wins).
REQ-024 SHALL increment cycles, modulo 2^CYC_W, and pulse wrap for one cycle on a STEP from phase 7 to phase 0 while LOCKED (state before the edge).
REQ-025 SHALL make cycles wrap from 2^CYC_W-1 to 0 with wrap=1 and no other flag.
REQ-026 SHALL keep cycles unchanged in UNLOCK and FAULT, with no clear except reset.
REQ-027 SHALL keep q_d updated every cycle in all states, including FAULT.

Reset
REQ-028 SHALL, on posedge clk with reset=1, force phase=0, legal=0, locked=0, err=0, cycles=0, wrap=0, state=UNLOCK, step counter=0, prev_valid=0, q_d=0, regardless of q or clr_err.
REQ-029 SHALL apply reset with identical effect in any state, including mid-cycle and FAULT.

Verification
REQ-030 SHALL cover lock acquisition: reset, then q=0,1,3,7 on successive edges -> locked=1 after the edge sampling 0x3; phase=3 after 0x7; err=0.
REQ-031 SHALL cover a full cycle: locked, q runs 0,1,3,7,F,E,C,8,0 -> cycles 0->1 and wrap=1 for exactly the one cycle after sampling 0 following 8.
REQ-032 SHALL cover an illegal code: locked, q=0x5 -> legal=0, err=1, locked=0; err held through 10 legal steps; clr_err pulse -> err=0; two further steps -> locked=1.
REQ-033 SHALL cover a skip: locked, q=0x1 then 0x7 -> err=1; simultaneous clr_err with a BAD sample in FAULT -> UNLOCK, err=0.
REQ-034 SHALL cover hold and wrap: locked, q=3,3,3 -> locked stays 1, err 0; with CYC_W=2, four full cycles -> cycles 1,2,3,0 with a wrap pulse each.
REQ-035 SHALL cover reset mid-operation: LOCKED with cycles=5, reset=1 for one edge -> all outputs 0; the next sample is not judged as STEP.
